// File: rtl/hpi_access_sequencer.sv
// Two-port arbiter that turns accepted requests into timed CY7C67200 HPI
// read/write cycles, and sequences the chip reset pulse.
module hpi_access_sequencer #(
    parameter int STROBE_CYCLES   = 4,
    parameter int RECOVERY_CYCLES = 2,
    parameter int RESET_CYCLES    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [1:0]  req0_addr,
    input  logic [15:0] req0_wdata,
    output logic        req0_ack,
    output logic        req0_rvalid,
    output logic [15:0] req0_rdata,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [1:0]  req1_addr,
    input  logic [15:0] req1_wdata,
    output logic        req1_ack,
    output logic        req1_rvalid,
    output logic [15:0] req1_rdata,
    input  logic        sw_reset,
    output logic        busy,
    output logic [1:0]  hpi_addr,
    output logic        hpi_cs_n,
    output logic        hpi_r_n,
    output logic        hpi_w_n,
    output logic [15:0] hpi_dout,
    output logic        hpi_dout_en,
    input  logic [15:0] hpi_din,
    output logic        hpi_reset_n
);
    typedef enum logic [2:0] {RST_HOLD, IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

    state_t      state, state_n, after_cycle;
    logic [7:0]  cnt, cnt_n;
    logic        last_grant, sw_pend, start, grant1;
    logic        cur_port, cur_write;
    logic        sel_write;
    logic [1:0]  sel_addr;
    logic [15:0] sel_wdata;
    logic        in_cyc, wr_cyc, rd_done;

    always_comb begin
        // last_grant = 1 means port 1 won last, so port 0 wins a tie
        grant1      = req1_valid && (!req0_valid || !last_grant);
        sel_write   = grant1 ? req1_write : req0_write;
        sel_addr    = grant1 ? req1_addr  : req0_addr;
        sel_wdata   = grant1 ? req1_wdata : req0_wdata;
        after_cycle = (RECOVERY_CYCLES == 0) ? IDLE : RECOVER;
        start       = 1'b0;
        state_n     = state;
        cnt_n       = cnt;
        case (state)
            RST_HOLD: begin
                if (cnt == 8'(RESET_CYCLES - 1)) begin
                    state_n = after_cycle;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            IDLE: begin
                if (sw_pend || sw_reset) begin
                    state_n = RST_HOLD;
                    cnt_n   = '0;
                end else if (req0_valid || req1_valid) begin
                    start   = 1'b1;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                state_n = STROBE;
                cnt_n   = '0;
            end
            STROBE: begin
                if (cnt == 8'(STROBE_CYCLES - 1)) state_n = HOLD;
                else                              cnt_n   = cnt + 8'd1;
            end
            HOLD: begin
                state_n = after_cycle;
                cnt_n   = '0;
            end
            RECOVER: begin
                if (cnt == 8'(RECOVERY_CYCLES - 1)) state_n = IDLE;
                else                                cnt_n   = cnt + 8'd1;
            end
            default: begin
                state_n = RST_HOLD;
                cnt_n   = '0;
            end
        endcase
        in_cyc  = state_n inside {SETUP, STROBE, HOLD};
        wr_cyc  = start ? sel_write : cur_write;
        rd_done = (state == STROBE) && (state_n == HOLD) && !cur_write;
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RST_HOLD;
            cnt         <= '0;
            last_grant  <= 1'b1;
            sw_pend     <= 1'b0;
            cur_port    <= 1'b0;
            cur_write   <= 1'b0;
            busy        <= 1'b1;
            hpi_reset_n <= 1'b0;
            hpi_cs_n    <= 1'b1;
            hpi_r_n     <= 1'b1;
            hpi_w_n     <= 1'b1;
            hpi_addr    <= '0;
            hpi_dout    <= '0;
            hpi_dout_en <= 1'b0;
            req0_ack    <= 1'b0;
            req1_ack    <= 1'b0;
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            req0_rdata  <= '0;
            req1_rdata  <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            sw_pend <= (sw_pend || sw_reset) && (state_n != RST_HOLD);
            if (start) begin
                last_grant <= grant1;
                cur_port   <= grant1;
                cur_write  <= sel_write;
                hpi_addr   <= sel_addr;
                if (sel_write) hpi_dout <= sel_wdata;
            end
            busy        <= (state_n != IDLE);
            hpi_reset_n <= (state_n != RST_HOLD);
            hpi_cs_n    <= !in_cyc;
            hpi_r_n     <= !((state_n == STROBE) && !cur_write);
            hpi_w_n     <= !((state_n == STROBE) && cur_write);
            hpi_dout_en <= in_cyc && wr_cyc;
            req0_ack    <= start && !grant1;
            req1_ack    <= start && grant1;
            req0_rvalid <= rd_done && !cur_port;
            req1_rvalid <= rd_done && cur_port;
            if (rd_done && !cur_port) req0_rdata <= hpi_din;
            if (rd_done && cur_port)  req1_rdata <= hpi_din;
        end
    end
endmodule

// File: doc/hpi_access_sequencer.md
Name: hpi_access_sequencer

Overview:
- Owns the CY7C67200 OTG host-port interface (HPI): 2-bit address, chip select, read/write strobes, 16-bit split data, and chip reset.
- Arbitrates between two requesters: port 0 is the CPU PIO bridge and port 1 is the hardware keyboard poller.
- Converts each accepted request into one timed HPI read or write cycle.
- Also sequences the chip reset pulse at power-up and on software request.

Parameters:
- STROBE_CYCLES, 4, clocks that hpi_r_n/hpi_w_n are held low (legal range 1-15).
- RECOVERY_CYCLES, 2, clocks that hpi_cs_n is held high after each cycle before the next setup (0-15).
- RESET_CYCLES, 16, clocks that hpi_reset_n is held low (legal range 1-255).

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high.
- req0_valid  in  1  port 0 request pending.
- req0_write  in  1  1 = write, 0 = read.
- req0_addr  in  2  HPI register select (0 = DATA, 1 = MAILBOX, 2 = ADDRESS, 3 = STATUS).
- req0_wdata  in  16  write data.
- req0_ack  out  1  one-cycle pulse: request accepted.
- req0_rvalid  out  1  one-cycle pulse: req0_rdata is valid.
- req0_rdata  out  16  read data.
- req1_valid, req1_write, req1_addr, req1_wdata, req1_ack, req1_rvalid, req1_rdata: same as port 0, for port 1.
- sw_reset  in  1  one-cycle pulse requesting a chip reset.
- busy  out  1  high in every state except IDLE.
- hpi_addr  out  2  HPI address.
- hpi_cs_n  out  1  chip select, active low.
- hpi_r_n  out  1  read strobe, active low.
- hpi_w_n  out  1  write strobe, active low.
- hpi_dout  out  16  write data to the pad.
- hpi_dout_en  out  1  pad output-enable for hpi_dout.
- hpi_din  in  16  read data from the pad.
- hpi_reset_n  out  1  chip reset, active low.

Behaviour:
- All outputs are registered.
- Reset values: hpi_cs_n, hpi_r_n and hpi_w_n = 1; hpi_reset_n = 0; hpi_addr = 0; hpi_dout = 0; hpi_dout_en = 0; all ack and rvalid = 0; all rdata = 0; busy = 1.
- Reset sends the FSM to RST_HOLD and sets the round-robin pointer so port 0 wins the first tie.
- FSM states: RST_HOLD, IDLE, SETUP, STROBE, HOLD, RECOVER.
- RST_HOLD:
  - hpi_reset_n = 0 for RESET_CYCLES clocks, then go to RECOVER (which drives hpi_reset_n = 1).
  - Requests are not sampled.
- IDLE:
  - A pending sw_reset goes to RST_HOLD and takes priority over requests.
  - Otherwise, if any reqN_valid is high, grant one port and capture write/addr/wdata.
  - Go to SETUP; the granted port's ack is high during the SETUP cycle.
- Arbitration:
  - If only one port is valid, it wins.
  - If both are valid, the port not granted last time wins (strict alternation).
- Requester rule: hold valid and fields stable until ack. The cycle after ack, present the next request or drop valid. Requests are sampled only in IDLE.
- SETUP (1 clock):
  - hpi_cs_n = 0 and hpi_addr is driven.
  - For a write, hpi_dout = wdata and hpi_dout_en = 1.
- STROBE (STROBE_CYCLES clocks): hpi_r_n or hpi_w_n = 0. For a read, hpi_din is registered on the final STROBE clock.
- HOLD (1 clock):
  - Strobes = 1; cs_n, addr and dout are still held.
  - For a read, the granted port's rdata is updated and rvalid pulses this cycle; the other port's rdata holds its value.
- RECOVER (RECOVERY_CYCLES clocks, 0 = skip):
  - hpi_cs_n = 1 and hpi_dout_en = 0.
  - Then go to IDLE.
- Timing with defaults:
  - Request sampled in IDLE at cycle t: ack at t+1, strobe low t+2..t+5, rvalid at t+6, IDLE again at t+9.
  - Back-to-back grants are 9 clocks apart.
- sw_reset arriving mid-transaction is latched; the current cycle completes, then RST_HOLD is entered from IDLE.
- Reset mid-transaction: at the next edge, strobes and cs_n go high, dout_en = 0, and the FSM enters RST_HOLD. The aborted request gets no rvalid; its ack may already have been given.
- busy = 1 in every state except IDLE.

Test Plan:
- Release Reset → hpi_reset_n stays 0 for 16 clocks then goes 1; busy = 0 after 2 recovery clocks; all strobes stay 1 throughout.
- Port 0 write, addr=2, wdata=0x1234 → req0_ack 1 clock after sampling; cs_n low for 6 clocks; w_n low exactly 4 clocks; hpi_dout = 0x1234 with dout_en = 1 across SETUP..HOLD; r_n never low.
- Port 1 read, addr=0, hpi_din = 0xBEEF during strobe → req1_rvalid pulses at t+6 with req1_rdata = 0xBEEF; req0_rvalid stays 0 and req0_rdata is unchanged.
- Both ports valid continuously for 4 grants → ack order 0, 1, 0, 1; grants spaced 9 clocks.
- Assert Reset during STROBE of a read → strobes go 1 next edge; no rvalid pulses; hpi_reset_n goes low for 16 clocks.
- sw_reset pulse during STROBE of a write → write completes with w_n low 4 clocks; RST_HOLD follows; a port 0 request pending meanwhile is acked only after reset recovery.
